// File: rtl/ag_video_fetch.sv
// ag_video_fetch: raster timing, video RAM fetch scheduling and 1-bit pixel
// serializer for the Agat 256x256 monochrome graphics mode.
module ag_video_fetch #(
  parameter int unsigned H_TOTAL      = 384,
  parameter int unsigned H_ACTIVE     = 256,
  parameter int unsigned H_SYNC_START = 288,
  parameter int unsigned H_SYNC_LEN   = 32,
  parameter int unsigned V_TOTAL      = 312,
  parameter int unsigned V_ACTIVE     = 256,
  parameter int unsigned V_SYNC_START = 272,
  parameter int unsigned V_SYNC_LEN   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PIX_EN,
  input  logic [1:0]  PAGE,
  output logic [13:0] AB2,
  output logic        CS2,
  input  logic [15:0] DO2,
  output logic        PIX,
  output logic        HS,
  output logic        VS,
  output logic        BLANK,
  output logic        VBL
);

  // hcnt must also hold the look-ahead position hcnt+3 before wrapping
  localparam int unsigned HW = $clog2(H_TOTAL + 3);
  localparam int unsigned VW = $clog2(V_TOTAL);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    page_r;
  logic          cs_d;
  logic [15:0]   prefetch;
  logic [15:0]   shreg;

  logic [HW-1:0] hahead_c;
  logic [HW-1:0] hmod_c;
  logic          hwrap_c;
  logic          h_last_c;
  logic          v_last_c;
  logic [VW-1:0] vnext_c;
  logic [VW-1:0] line_c;
  logic          fetch_c;
  logic          active_c;
  logic          load_c;
  logic [15:0]   order_c;

  // Position decode and fetch decision, three pixels ahead of display
  always_comb begin
    hahead_c = hcnt + HW'(3);
    hwrap_c  = (hahead_c >= HW'(H_TOTAL));
    hmod_c   = hwrap_c ? (hahead_c - HW'(H_TOTAL)) : hahead_c;
    h_last_c = (hcnt == HW'(H_TOTAL - 1));
    v_last_c = (vcnt == VW'(V_TOTAL - 1));
    vnext_c  = v_last_c ? '0 : (vcnt + VW'(1));
    line_c   = hwrap_c ? vnext_c : vcnt;
    fetch_c  = PIX_EN && (hmod_c[3:0] == 4'd0) && (hmod_c < HW'(H_ACTIVE))
               && (line_c < VW'(V_ACTIVE));
    active_c = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    load_c   = active_c && (hcnt[3:0] == 4'd0);
    // Even-address byte [7:0] goes out first, MSB first within each byte
    order_c  = {prefetch[7:0], prefetch[15:8]};
  end

  // Raster counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (PIX_EN) begin
      if (h_last_c) begin
        hcnt <= '0;
        vcnt <= vnext_c;
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // Page is latched once per frame during vertical sync
  always_ff @(posedge CLK) begin
    if (RST) begin
      page_r <= 2'd0;
    end else if (PIX_EN && (hcnt == '0) && (vcnt == VW'(V_SYNC_START))) begin
      page_r <= PAGE;
    end
  end

  // Video RAM request and read-data capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      AB2      <= 14'd0;
      CS2      <= 1'b0;
      cs_d     <= 1'b0;
      prefetch <= 16'd0;
    end else begin
      CS2  <= fetch_c;
      cs_d <= CS2;
      if (fetch_c) begin
        AB2 <= {page_r, line_c[7:0], hmod_c[7:4]};
      end
      if (cs_d) begin
        prefetch <= DO2;
      end
    end
  end

  // Pixel serializer
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg <= 16'd0;
      PIX   <= 1'b0;
    end else if (PIX_EN) begin
      if (load_c) begin
        PIX   <= order_c[15];
        shreg <= {order_c[14:0], 1'b0};
      end else if (active_c) begin
        PIX   <= shreg[15];
        shreg <= {shreg[14:0], 1'b0};
      end else begin
        PIX   <= 1'b0;
      end
    end
  end

  // Sync, blanking and vertical-blank strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      HS    <= 1'b0;
      VS    <= 1'b0;
      BLANK <= 1'b1;
      VBL   <= 1'b0;
    end else begin
      VBL <= PIX_EN && (hcnt == '0) && (vcnt == VW'(V_ACTIVE));
      if (PIX_EN) begin
        HS    <= (hcnt >= HW'(H_SYNC_START)) &&
                 (hcnt < HW'(H_SYNC_START + H_SYNC_LEN));
        VS    <= (vcnt >= VW'(V_SYNC_START)) &&
                 (vcnt < VW'(V_SYNC_START + V_SYNC_LEN));
        BLANK <= !active_c;
      end
    end
  end

endmodule

// File: tb/tb_ag_video_fetch.sv
// Scoreboard bench for ag_video_fetch: a frame-level reference model queues
// expected pixels/syncs and fetch addresses; a monitor pops and compares.
`timescale 1ns/1ps
module tb_ag_video_fetch;

  // Reduced geometry keeps a full frame plus part of the next within budget
  localparam int H_TOTAL      = 272;
  localparam int H_ACTIVE     = 256;
  localparam int H_SYNC_START = 260;
  localparam int H_SYNC_LEN   = 8;
  localparam int V_TOTAL      = 258;
  localparam int V_ACTIVE     = 256;
  localparam int V_SYNC_START = 257;
  localparam int V_SYNC_LEN   = 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PIX_EN;
  logic [1:0]  PAGE;
  logic [13:0] AB2;
  logic        CS2;
  logic [15:0] DO2;
  logic        PIX;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic        VBL;

  always #5 CLK = ~CLK;

  ag_video_fetch #(
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_LEN(H_SYNC_LEN),
    .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE),
    .V_SYNC_START(V_SYNC_START), .V_SYNC_LEN(V_SYNC_LEN)
  ) dut (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN), .PAGE(PAGE),
    .AB2(AB2), .CS2(CS2), .DO2(DO2),
    .PIX(PIX), .HS(HS), .VS(VS), .BLANK(BLANK), .VBL(VBL)
  );

  // Synchronous-read video RAM
  logic [15:0] mem [16384];
  always @(posedge CLK) if (CS2) DO2 <= mem[AB2];

  typedef struct {
    int h;
    int v;
    int frame;
    bit pix;
    bit hs;
    bit vs;
    bit blank;
  } exp_t;

  exp_t        pq[$];
  logic [13:0] aq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Displayed bit for screen position (h,v) taken straight from the RAM image
  function automatic bit ref_pix(input int h, input int v, input int pg, input bit first);
    logic [15:0] w;
    int p;
    if (h >= H_ACTIVE || v >= V_ACTIVE) return 1'b0;
    if (first && v == 0 && h < 16) return 1'b0;
    w = mem[pg * 4096 + v * 16 + h / 16];
    p = h % 16;
    return (p < 8) ? w[7 - p] : w[23 - p];
  endfunction

  // Reference model: tracks screen position and frame page
  int mh = 0, mv = 0, mframe = 0, disp_page = 0, next_page = 0;
  bit exp_vbl = 1'b0;
  always @(posedge CLK) begin
    exp_t e;
    exp_vbl = 1'b0;
    if (RST) begin
      mh = 0; mv = 0; mframe = 0; disp_page = 0; next_page = 0;
      pq.delete();
      aq.delete();
      // First frame after reset: every word of page 0 except line 0 word 0
      for (int l = 0; l < 256; l++)
        for (int k = 0; k < 16; k++)
          if (l != 0 || k != 0) aq.push_back(14'(l * 16 + k));
    end else if (PIX_EN) begin
      e.h = mh; e.v = mv; e.frame = mframe;
      e.pix   = ref_pix(mh, mv, disp_page, mframe == 0);
      e.hs    = (mh >= H_SYNC_START && mh < H_SYNC_START + H_SYNC_LEN);
      e.vs    = (mv >= V_SYNC_START && mv < V_SYNC_START + V_SYNC_LEN);
      e.blank = !(mh < H_ACTIVE && mv < V_ACTIVE);
      pq.push_back(e);
      exp_vbl = (mh == 0 && mv == V_ACTIVE);
      if (mh == 0 && mv == V_SYNC_START) begin
        next_page = int'(PAGE);
        for (int l = 0; l < 256; l++)
          for (int k = 0; k < 16; k++)
            aq.push_back(14'(next_page * 4096 + l * 16 + k));
      end
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv++;
        if (mv == V_TOTAL) begin
          mv = 0;
          mframe++;
          disp_page = next_page;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations
  bit          cs_prev = 1'b0;
  int          cs_cnt = 0, hs_cnt = 0, vs_cnt = 0, blank_lo = 0, vbl_cnt = 0, bo_cnt = 0;
  logic [15:0] bo_vec = 16'd0;
  always @(negedge CLK) begin
    exp_t e;
    logic [13:0] a;
    if (RST) begin
      cs_prev = 1'b0;
    end else begin
      check("vbl", VBL, exp_vbl);
      if (VBL) vbl_cnt++;
      if (CS2) begin
        cs_cnt++;
        check("cs2_single_clk", cs_prev, 0);
        if (aq.size() == 0) begin
          check("addr_unexpected", 1, 0);
        end else begin
          a = aq.pop_front();
          check("addr", AB2, a);
        end
      end
      cs_prev = CS2;
      if (pq.size() > 0) begin
        e = pq.pop_front();
        check("pix_hs_vs_blank", {PIX, HS, VS, BLANK}, {e.pix, e.hs, e.vs, e.blank});
        if (HS) hs_cnt++;
        if (e.h == 0 && VS) vs_cnt++;
        if (!BLANK) blank_lo++;
        if (e.h == H_TOTAL - 1) begin
          check("hs_per_line", hs_cnt, H_SYNC_LEN);
          hs_cnt = 0;
        end
        if (e.frame == 0 && e.h == 0 && e.v == V_SYNC_START)
          check("frame0_fetch_count", cs_cnt, 4095);
        if (e.frame == 0 && e.h == H_TOTAL - 1 && e.v == V_TOTAL - 1) begin
          check("vs_lines", vs_cnt, V_SYNC_LEN);
          check("active_pixels", blank_lo, 65536);
          check("vbl_pulses", vbl_cnt, 1);
        end
        if (e.frame == 1 && e.v == 5 && e.h >= 48 && e.h < 64) begin
          bo_vec[e.h - 48] = PIX;
          bo_cnt++;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    int guard;
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    mem[2 * 4096 + 5 * 16 + 3] = 16'h8001;
    RST = 1'b1; PIX_EN = 1'b1; PAGE = 2'd0;
    repeat (3) begin
      @(negedge CLK);
      check("rst_outputs", {AB2, CS2, PIX, HS, VS, BLANK, VBL}, {14'h0, 6'b000010});
    end
    RST = 1'b0;
    // Frame 0 with continuous PIX_EN; page moves to 2 mid-frame
    for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
      if (i == 100 * H_TOTAL) PAGE = 2'd2;
      @(negedge CLK);
    end
    // Frame 1, lines 0..3: PIX_EN once every 4 CLK
    for (int j = 0; j < 4 * H_TOTAL; j++) begin
      PIX_EN = 1'b1;
      @(negedge CLK);
      PIX_EN = 1'b0;
      repeat (3) @(negedge CLK);
    end
    // Frame 1, lines 4..6: random PIX_EN
    n = 0;
    guard = 0;
    while (n < 3 * H_TOTAL && guard < 20000) begin
      PIX_EN = 1'($urandom_range(0, 1));
      if (PIX_EN) n++;
      guard++;
      @(negedge CLK);
    end
    check("random_phase_done", n, 3 * H_TOTAL);
    PIX_EN = 1'b0;
    repeat (4) @(negedge CLK);
    check("pixel_queue_drained", pq.size(), 0);
    check("frame1_fetch_remaining", aq.size(), 4096 - 113);
    check("bitorder_count", bo_cnt, 16);
    check("bitorder_word", bo_vec, 16'h0180);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
